instr_fetch_stage: RTL and testbench

- Fetch stage plus IF/ID pipeline register of the RISC-V RV32I 5-stage core.
- Holds the fetch PC and drives the instruction-memory address.
- Registers the fetched instruction, PC and PC+4 for the decode stage. Decode feeds instr_d_o directly to the immediate decoder and control unit.
- Handles hazard-unit stall, branch/jump flush and PC redirect.

---
 rtl/instr_fetch_stage_if.sv | 22 ++
 rtl/instr_fetch_stage.sv | 92 +++++++++
 tb/tb_instr_fetch_stage.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory fetch port: request/address out, word/ready back.
// Memory is combinational-ready; there are no outstanding transactions.
interface instr_fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_ready
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_ready
   );
endinterface

// File: rtl/instr_fetch_stage.sv
// RV32I fetch stage and IF/ID pipeline register with stall, flush and PC redirect.
// Redirect beats stall for the PC; flush/redirect beats stall for IF/ID.
module instr_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       stall_i,
   input  logic                       flush_i,
   input  logic                       pc_src_i,
   input  logic [31:0]                pc_target_i,
   instr_fetch_stage_if.master        imem,
   output logic [31:0]                instr_d_o,
   output logic [31:0]                pc_d_o,
   output logic [31:0]                pc_plus4_d_o,
   output logic                       valid_d_o
);

   localparam logic [31:0] AlignMask = 32'hFFFF_FFFC;

   logic [31:0] pc_f_q, pc_f_d;
   logic        req_en_q;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_id_q, pc_id_d;
   logic [31:0] pc_plus4_q, pc_plus4_d;
   logic        valid_q, valid_d;
   logic [31:0] pc_f_plus4;
   logic        fetch_ok;

   assign imem.imem_req  = req_en_q;
   assign imem.imem_addr = pc_f_q;
   assign fetch_ok       = req_en_q & imem.imem_ready;
   assign pc_f_plus4     = pc_f_q + 32'd4;

   always_comb begin
      pc_f_d = pc_f_q;
      if (pc_src_i) begin
         pc_f_d = pc_target_i & AlignMask;
      end else if (stall_i) begin
         pc_f_d = pc_f_q;
      end else if (fetch_ok) begin
         pc_f_d = pc_f_plus4;
      end
   end

   // Bubbles keep the old PC fields; only instr/valid change.
   always_comb begin
      instr_d    = instr_q;
      pc_id_d    = pc_id_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
      if (flush_i || pc_src_i) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (stall_i) begin
         valid_d = valid_q;
      end else if (fetch_ok) begin
         instr_d    = imem.imem_rdata;
         pc_id_d    = pc_f_q;
         pc_plus4_d = pc_f_plus4;
         valid_d    = 1'b1;
      end else begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_f_q     <= RESET_PC & AlignMask;
         req_en_q   <= 1'b0;
         instr_q    <= NOP_INSTR;
         pc_id_q    <= 32'h0;
         pc_plus4_q <= 32'h0;
         valid_q    <= 1'b0;
      end else begin
         pc_f_q     <= pc_f_d;
         req_en_q   <= 1'b1;
         instr_q    <= instr_d;
         pc_id_q    <= pc_id_d;
         pc_plus4_q <= pc_plus4_d;
         valid_q    <= valid_d;
      end
   end

   assign instr_d_o    = instr_q;
   assign pc_d_o       = pc_id_q;
   assign pc_plus4_d_o = pc_plus4_q;
   assign valid_d_o    = valid_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: reset, streaming, stall, redirect,
// memory wait, flush+stall, reset mid-run, and PC wrap on a second instance.
module tb_instr_fetch_stage;

   localparam logic [31:0] Nop = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst_n, stall, flush, pc_src;
   logic [31:0] pc_target;

   logic [31:0] instr_a, pc_a, plus4_a;
   logic        valid_a;
   logic [31:0] instr_b, pc_b, plus4_b;
   logic        valid_b;

   int n_checks = 0;
   int n_errors = 0;

   instr_fetch_stage_if bus_a ();
   instr_fetch_stage_if bus_b ();

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A00_0000;
   endfunction

   assign bus_a.imem_rdata = mem_word(bus_a.imem_addr);
   assign bus_b.imem_rdata = mem_word(bus_b.imem_addr);
   assign bus_b.imem_ready = 1'b1;

   instr_fetch_stage #(
      .RESET_PC (32'h0000_0000),
      .NOP_INSTR(Nop)
   ) dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall_i     (stall),
      .flush_i     (flush),
      .pc_src_i    (pc_src),
      .pc_target_i (pc_target),
      .imem        (bus_a.master),
      .instr_d_o   (instr_a),
      .pc_d_o      (pc_a),
      .pc_plus4_d_o(plus4_a),
      .valid_d_o   (valid_a)
   );

   instr_fetch_stage #(
      .RESET_PC (32'hFFFF_FFF8),
      .NOP_INSTR(Nop)
   ) dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall_i     (stall),
      .flush_i     (flush),
      .pc_src_i    (pc_src),
      .pc_target_i (pc_target),
      .imem        (bus_b.master),
      .instr_d_o   (instr_b),
      .pc_d_o      (pc_b),
      .pc_plus4_d_o(plus4_b),
      .valid_d_o   (valid_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full IF/ID view of instance A after an edge.
   task automatic check_a(input string tag, input logic [31:0] addr, input logic [31:0] pc,
                          input logic vld, input logic [31:0] instr);
      check({tag, ".addr"}, bus_a.imem_addr, addr);
      check({tag, ".pc_d"}, pc_a, pc);
      check({tag, ".valid"}, {31'h0, valid_a}, {31'h0, vld});
      check({tag, ".instr"}, instr_a, instr);
   endtask

   initial begin
      rst_n = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      pc_src = 1'b0;
      pc_target = 32'h0;
      bus_a.imem_ready = 1'b1;
      step();
      step();

      check("rst.req", {31'h0, bus_a.imem_req}, 32'h0);
      check("rst.plus4", plus4_a, 32'h0);
      check_a("rst", 32'h0, 32'h0, 1'b0, Nop);
      check("rst_b.addr", bus_b.imem_addr, 32'hFFFF_FFF8);

      // First edge after release only enables requests.
      rst_n = 1'b1;
      step();
      check("rel.req", {31'h0, bus_a.imem_req}, 32'h1);
      check_a("rel", 32'h0, 32'h0, 1'b0, Nop);

      for (int i = 0; i < 3; i++) begin
         step();
         check_a($sformatf("run%0d", i), 32'(4 * (i + 1)), 32'(4 * i), 1'b1, mem_word(32'(4 * i)));
         check($sformatf("run%0d.plus4", i), plus4_a, 32'(4 * i + 4));
      end

      // Instance B crosses the 2^32 boundary during the same edges.
      check("wrap.addr", bus_b.imem_addr, 32'h0000_0004);
      check("wrap.pc_d", pc_b, 32'h0000_0000);
      check("wrap.valid", {31'h0, valid_b}, 32'h1);

      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_a($sformatf("stall%0d", i), 32'hC, 32'h8, 1'b1, mem_word(32'h8));
      end
      stall = 1'b0;
      step();
      check_a("unstall", 32'h10, 32'hC, 1'b1, mem_word(32'hC));

      // Redirect overrides stall; target low bits are dropped.
      stall = 1'b1;
      pc_src = 1'b1;
      pc_target = 32'h0000_0102;
      step();
      check_a("redir", 32'h100, 32'hC, 1'b0, Nop);
      stall = 1'b0;
      pc_src = 1'b0;
      step();
      check_a("redir_cap", 32'h104, 32'h100, 1'b1, mem_word(32'h100));
      check("redir_cap.plus4", plus4_a, 32'h104);

      pc_src = 1'b1;
      pc_target = 32'h20;
      step();
      pc_src = 1'b0;
      bus_a.imem_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         check_a($sformatf("wait%0d", i), 32'h20, 32'h100, 1'b0, Nop);
      end
      bus_a.imem_ready = 1'b1;
      step();
      check_a("wait_cap", 32'h24, 32'h20, 1'b1, mem_word(32'h20));

      // Flush beats stall for IF/ID; PC holds.
      stall = 1'b1;
      flush = 1'b1;
      step();
      check_a("flush_stall", 32'h24, 32'h20, 1'b0, Nop);

      rst_n = 1'b0;
      step();
      check("rst2.req", {31'h0, bus_a.imem_req}, 32'h0);
      check("rst2.plus4", plus4_a, 32'h0);
      check_a("rst2", 32'h0, 32'h0, 1'b0, Nop);

      rst_n = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      step();
      check("rst2_rel.req", {31'h0, bus_a.imem_req}, 32'h1);
      step();
      check_a("rst2_run", 32'h4, 32'h0, 1'b1, mem_word(32'h0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Wrap checks on instance B sampled at fixed edges after release.
   initial begin
      wait (rst_n === 1'b1);
      step();
      step();
      check("wrapb0.pc_d", pc_b, 32'hFFFF_FFF8);
      check("wrapb0.addr", bus_b.imem_addr, 32'hFFFF_FFFC);
      step();
      check("wrapb1.pc_d", pc_b, 32'hFFFF_FFFC);
      check("wrapb1.plus4", plus4_b, 32'h0000_0000);
      check("wrapb1.addr", bus_b.imem_addr, 32'h0000_0000);
      check("wrapb1.instr", instr_b, mem_word(32'hFFFF_FFFC));
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
